// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit queue.
package uart_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned DEPTH_LOG2_DEF = 4;
   localparam int unsigned RETRY_WAIT_DEF = 8;
   // Transmitter edge detector needs this many low cycles between requests
   localparam int unsigned MIN_IRQ_GAP    = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Push-side and transmitter-side signals of uart_tx_queue.
// Optional ovf_cnt_o exists only when UART_TXQ_OVF_CNT_EN is defined.
interface uart_tx_queue_if import uart_pkg::*; #(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
);
   logic                push_i;
   logic [BYTE_W-1:0]   push_data_i;
   logic                full_o;
   logic                empty_o;
   logic [DEPTH_LOG2:0] level_o;
   logic                tx_irq_o;
   logic [BYTE_W-1:0]   tx_data_o;
   logic                tx_busy_i;
`ifdef UART_TXQ_OVF_CNT_EN
   logic [7:0]          ovf_cnt_o;
`endif

   modport master (
      output push_i, push_data_i, tx_busy_i,
      input  full_o, empty_o, level_o, tx_irq_o, tx_data_o
`ifdef UART_TXQ_OVF_CNT_EN
      , input ovf_cnt_o
`endif
   );

   modport slave (
      input  push_i, push_data_i, tx_busy_i,
      output full_o, empty_o, level_o, tx_irq_o, tx_data_o
`ifdef UART_TXQ_OVF_CNT_EN
      , output ovf_cnt_o
`endif
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level; head is read combinationally.
module uart_sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [WIDTH-1:0]    push_data_i,
   input  logic                pop_i,
   output logic [WIDTH-1:0]    head_c,
   output logic                full_o,
   output logic                empty_o,
   output logic [DEPTH_LOG2:0] level_o
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned PTR_W = DEPTH_LOG2;
   localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             wr_en;
   logic             rd_en;

   // A push while full is dropped even if a pop frees a slot in the same cycle
   always_comb begin
      wr_en    = push_i && !full_q;
      rd_en    = pop_i && !empty_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_data_i;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign head_c  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter through a one-cycle irq handshake with retry.
// Define UART_TXQ_OVF_CNT_EN to add the saturating dropped-push counter ovf_cnt_o.
module uart_tx_queue import uart_pkg::*; #(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int unsigned RETRY_WAIT = RETRY_WAIT_DEF
) (
   input  logic      clk_i,
   input  logic      rst_i,
   uart_tx_queue_if.slave bus
);

   // Retry period never shorter than the irq low time the transmitter needs
   localparam int unsigned RETRY_CYC = (RETRY_WAIT < MIN_IRQ_GAP) ? MIN_IRQ_GAP : RETRY_WAIT;
   localparam int unsigned CNT_W     = $clog2(RETRY_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RETRY_CYC - 1);

   txq_state_e        state_q, state_d;
   logic [BYTE_W-1:0] tx_data_q, tx_data_d;
   logic              tx_irq_q, tx_irq_d;
   logic [CNT_W-1:0]  retry_cnt_q, retry_cnt_d;
   logic              fifo_pop;
   logic [BYTE_W-1:0] fifo_head;

   uart_sync_fifo #(
      .WIDTH      (BYTE_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (bus.push_i),
      .push_data_i (bus.push_data_i),
      .pop_i       (fifo_pop),
      .head_c      (fifo_head),
      .full_o      (bus.full_o),
      .empty_o     (bus.empty_o),
      .level_o     (bus.level_o)
   );

   // tx_data only changes on a pop, so it holds from ISSUE until the next IDLE pop
   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      retry_cnt_d = retry_cnt_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!bus.empty_o && !bus.tx_busy_i) begin
               fifo_pop  = 1'b1;
               tx_data_d = fifo_head;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            retry_cnt_d = '0;
            state_d     = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (retry_cnt_q == CNT_LAST) begin
               state_d = ST_ISSUE;
            end else begin
               retry_cnt_d = retry_cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.tx_busy_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      tx_irq_d = (state_d == ST_ISSUE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= '0;
         tx_irq_q    <= 1'b0;
         retry_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_irq_q    <= tx_irq_d;
         retry_cnt_q <= retry_cnt_d;
      end
   end

   assign bus.tx_irq_o  = tx_irq_q;
   assign bus.tx_data_o = tx_data_q;

`ifdef UART_TXQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   // Counts pushes rejected by a full queue, saturating
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (bus.push_i && bus.full_o && (ovf_cnt_q != 8'hFF)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign bus.ovf_cnt_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: transmitter model, protocol monitor and scenario tasks.
module tb_uart_tx_queue;

   localparam int unsigned LW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH_LOG2(4)) bus ();

   logic busy_manual;
   logic busy_model;
   logic model_en;
   assign bus.tx_busy_i = model_en ? busy_model : busy_manual;

   uart_tx_queue #(.DEPTH_LOG2(4), .RETRY_WAIT(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   int pulse_cnt = 0;

   // Transmitter model state
   int pend = 0;
   int hold = 0;
   int dly_len = 3;
   int hold_len = 40;
   bit rand_busy = 1'b0;
   logic [7:0] frames [$];

   // Monitor state
   logic [7:0] cap_byte = 8'h00;
   bit cap_valid = 1'b0;
   bit seen_pulse = 1'b0;
   bit prev_irq = 1'b0;
   int low_run = 0;

`ifdef UART_TXQ_OVF_CNT_EN
   int ovf_mdl = 0;
`endif

   // Protocol monitor plus a transmitter that raises busy dly cycles after irq
   always @(negedge clk) begin
      if (rst) begin
         cap_valid  = 1'b0;
         seen_pulse = 1'b0;
         prev_irq   = 1'b0;
         low_run    = 0;
      end else begin
         if (bus.tx_irq_o) begin
            pulse_cnt++;
            checks++;
            if (prev_irq) begin failures++; $display("FAIL irq_width got=multi-cycle exp=1 cycle"); end
            checks++;
            if (seen_pulse && low_run < 3) begin failures++; $display("FAIL irq_gap got=%0d exp>=3", low_run); end
            checks++;
            if (bus.tx_busy_i) begin failures++; $display("FAIL irq_while_busy got=1 exp=0"); end
            cap_byte   = bus.tx_data_o;
            cap_valid  = 1'b1;
            seen_pulse = 1'b1;
            low_run    = 0;
         end else begin
            low_run++;
         end
         prev_irq = bus.tx_irq_o;
         if (cap_valid) begin
            checks++;
            if (bus.tx_data_o !== cap_byte) begin
               failures++; $display("FAIL data_stable got=%0h exp=%0h", bus.tx_data_o, cap_byte);
            end
         end
      end
      if (model_en) begin
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               busy_model = 1'b1;
               hold = rand_busy ? int'($urandom_range(30, 5)) : hold_len;
               frames.push_back(bus.tx_data_o);
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) busy_model = 1'b0;
         end else if (bus.tx_irq_o && !rst) begin
            pend = rand_busy ? int'($urandom_range(5, 1)) : dly_len;
         end
      end
   end

   task automatic wait_drain(input int n, input int budget);
      int cyc = 0;
      while (!(frames.size() >= n && !bus.tx_busy_i && bus.empty_o && !bus.tx_irq_o
               && pend == 0 && hold == 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc >= budget) begin
         failures++; $display("FAIL drain_timeout got=%0d frames exp=%0d", frames.size(), n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (bus.tx_irq_o !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", bus.tx_irq_o); end
      checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=00", bus.tx_data_o); end
      checks++; if (bus.level_o !== LW'(0)) begin failures++; $display("FAIL rst_level got=%0d exp=0", bus.level_o); end
      checks++; if (bus.empty_o !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", bus.empty_o); end
      checks++; if (bus.full_o !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", bus.full_o); end
`ifdef UART_TXQ_OVF_CNT_EN
      checks++; if (bus.ovf_cnt_o !== 8'h00) begin failures++; $display("FAIL rst_ovf got=%0h exp=00", bus.ovf_cnt_o); end
      ovf_mdl = 0;
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      frames.delete();
      dly_len = 3; hold_len = 40; rand_busy = 1'b0; model_en = 1'b1;
      @(negedge clk);
      bus.push_i = 1'b1; bus.push_data_i = 8'h41;
      @(negedge clk);
      bus.push_i = 1'b0;
      checks++; if (bus.level_o !== LW'(1)) begin failures++; $display("FAIL single_level1 got=%0d exp=1", bus.level_o); end
      checks++; if (bus.tx_irq_o !== 1'b0) begin failures++; $display("FAIL single_irq_early got=%b exp=0", bus.tx_irq_o); end
      @(negedge clk);
      checks++; if (bus.tx_irq_o !== 1'b1) begin failures++; $display("FAIL single_irq got=%b exp=1", bus.tx_irq_o); end
      checks++; if (bus.tx_data_o !== 8'h41) begin failures++; $display("FAIL single_data got=%0h exp=41", bus.tx_data_o); end
      checks++; if (bus.level_o !== LW'(0)) begin failures++; $display("FAIL single_level0 got=%0d exp=0", bus.level_o); end
      @(negedge clk);
      checks++; if (bus.tx_irq_o !== 1'b0) begin failures++; $display("FAIL single_irq_end got=%b exp=0", bus.tx_irq_o); end
      wait_drain(1, 200);
      checks++; if (frames.size() != 1 || frames[0] !== 8'h41) begin
         failures++; $display("FAIL single_frame got=%0d frames exp=1 of 41", frames.size());
      end
   endtask

   task automatic test_retry();
      frames.delete();
      model_en = 1'b0; busy_manual = 1'b0;
      @(negedge clk);
      bus.push_i = 1'b1; bus.push_data_i = 8'h5A;
      @(negedge clk);
      bus.push_data_i = 8'h5B;
      checks++; if (bus.level_o !== LW'(1)) begin failures++; $display("FAIL retry_level_a got=%0d exp=1", bus.level_o); end
      @(negedge clk);
      bus.push_i = 1'b0;
      checks++; if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h5A) begin
         failures++; $display("FAIL retry_first got=%b/%0h exp=1/5a", bus.tx_irq_o, bus.tx_data_o);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (bus.tx_irq_o !== 1'b0) begin failures++; $display("FAIL retry_gap%0d got=%b exp=0", i, bus.tx_irq_o); end
         checks++; if (bus.level_o !== LW'(1)) begin failures++; $display("FAIL retry_level%0d got=%0d exp=1", i, bus.level_o); end
      end
      model_en = 1'b1; dly_len = 3; hold_len = 30;
      @(negedge clk);
      checks++; if (bus.tx_irq_o !== 1'b1 || bus.tx_data_o !== 8'h5A) begin
         failures++; $display("FAIL retry_repulse got=%b/%0h exp=1/5a", bus.tx_irq_o, bus.tx_data_o);
      end
      checks++; if (bus.level_o !== LW'(1)) begin failures++; $display("FAIL retry_level_b got=%0d exp=1", bus.level_o); end
      wait_drain(2, 400);
      checks++; if (frames.size() != 2 || frames[0] !== 8'h5A || frames[1] !== 8'h5B) begin
         failures++; $display("FAIL retry_frames got=%0d frames exp=5a,5b", frames.size());
      end
   endtask

   task automatic test_abc();
      logic [7:0] abc [3];
      int p0;
      abc = '{8'h41, 8'h42, 8'h43};
      frames.delete();
      model_en = 1'b1; rand_busy = 1'b0; dly_len = 3; hold_len = 434;
      p0 = pulse_cnt;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         bus.push_i = 1'b1; bus.push_data_i = abc[i];
         @(negedge clk);
      end
      bus.push_i = 1'b0;
      wait_drain(3, 2000);
      checks++; if (frames.size() != 3) begin failures++; $display("FAIL abc_count got=%0d exp=3", frames.size()); end
      for (int i = 0; i < 3 && i < frames.size(); i++) begin
         checks++; if (frames[i] !== abc[i]) begin failures++; $display("FAIL abc_byte%0d got=%0h exp=%0h", i, frames[i], abc[i]); end
      end
      checks++; if (pulse_cnt - p0 != 3) begin failures++; $display("FAIL abc_pulses got=%0d exp=3", pulse_cnt - p0); end
   endtask

   task automatic test_fill_overflow();
      frames.delete();
      @(negedge clk);
      model_en = 1'b0; busy_manual = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         bus.push_i = 1'b1; bus.push_data_i = 8'(i);
         @(negedge clk);
         checks++; if (bus.level_o !== LW'(i + 1)) begin failures++; $display("FAIL fill_level%0d got=%0d exp=%0d", i, bus.level_o, i + 1); end
      end
      checks++; if (bus.full_o !== 1'b1 || bus.empty_o !== 1'b0) begin
         failures++; $display("FAIL fill_flags got=%b/%b exp=1/0", bus.full_o, bus.empty_o);
      end
      bus.push_data_i = 8'hEE;
      @(negedge clk);
      checks++; if (bus.level_o !== LW'(16)) begin failures++; $display("FAIL drop17_level got=%0d exp=16", bus.level_o); end
`ifdef UART_TXQ_OVF_CNT_EN
      ovf_mdl = (ovf_mdl < 255) ? ovf_mdl + 1 : 255;
      checks++; if (bus.ovf_cnt_o !== 8'(ovf_mdl)) begin failures++; $display("FAIL ovf_one got=%0d exp=%0d", bus.ovf_cnt_o, ovf_mdl); end
`endif
      for (int i = 0; i < 300; i++) begin
         bus.push_data_i = 8'($urandom);
         @(negedge clk);
`ifdef UART_TXQ_OVF_CNT_EN
         ovf_mdl = (ovf_mdl < 255) ? ovf_mdl + 1 : 255;
`endif
      end
      checks++; if (bus.level_o !== LW'(16) || bus.full_o !== 1'b1) begin
         failures++; $display("FAIL drop300_level got=%0d exp=16", bus.level_o);
      end
`ifdef UART_TXQ_OVF_CNT_EN
      checks++; if (bus.ovf_cnt_o !== 8'(ovf_mdl)) begin failures++; $display("FAIL ovf_sat got=%0h exp=%0h", bus.ovf_cnt_o, ovf_mdl); end
`endif
      // Release busy so a pop coincides with a push that must still drop
      busy_manual = 1'b0; bus.push_data_i = 8'hDD;
      @(negedge clk);
      bus.push_i = 1'b0;
      checks++; if (bus.level_o !== LW'(15) || bus.full_o !== 1'b0) begin
         failures++; $display("FAIL pop_drop_level got=%0d exp=15", bus.level_o);
      end
      hold_len = 20; dly_len = 3; rand_busy = 1'b0; model_en = 1'b1;
      wait_drain(16, 1500);
      checks++; if (frames.size() != 16) begin failures++; $display("FAIL drain_count got=%0d exp=16", frames.size()); end
      for (int i = 0; i < 16 && i < frames.size(); i++) begin
         checks++; if (frames[i] !== 8'(i)) begin failures++; $display("FAIL drain_byte%0d got=%0h exp=%0h", i, frames[i], i); end
      end
      checks++; if (bus.level_o !== LW'(0) || bus.empty_o !== 1'b1) begin
         failures++; $display("FAIL drain_empty got=%0d exp=0", bus.level_o);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q [$];
      logic [7:0] b;
      frames.delete();
      model_en = 1'b1; rand_busy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(40, 0)) @(negedge clk);
         b = 8'($urandom);
         exp_q.push_back(b);
         bus.push_i = 1'b1; bus.push_data_i = b;
         @(negedge clk);
         bus.push_i = 1'b0;
      end
      wait_drain(12, 3000);
      rand_busy = 1'b0;
      checks++; if (frames.size() != exp_q.size()) begin
         failures++; $display("FAIL rand_count got=%0d exp=%0d", frames.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < frames.size(); i++) begin
         checks++; if (frames[i] !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got=%0h exp=%0h", i, frames[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_wait_done();
      int cyc;
      int p0;
      frames.delete();
      model_en = 1'b1; rand_busy = 1'b0; dly_len = 3; hold_len = 434;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         bus.push_i = 1'b1; bus.push_data_i = 8'h60 + 8'(i);
         @(negedge clk);
      end
      bus.push_i = 1'b0;
      cyc = 0;
      while (busy_model !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
      checks++; if (cyc >= 50) begin failures++; $display("FAIL rwd_busy_timeout got=%0d exp<50", cyc); end
      repeat (2) @(negedge clk);
      checks++; if (bus.level_o !== LW'(5)) begin failures++; $display("FAIL rwd_level got=%0d exp=5", bus.level_o); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.tx_irq_o !== 1'b0) begin failures++; $display("FAIL rwd_irq got=%b exp=0", bus.tx_irq_o); end
      checks++; if (bus.tx_data_o !== 8'h00) begin failures++; $display("FAIL rwd_data got=%0h exp=00", bus.tx_data_o); end
      checks++; if (bus.level_o !== LW'(0)) begin failures++; $display("FAIL rwd_level0 got=%0d exp=0", bus.level_o); end
      checks++; if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin
         failures++; $display("FAIL rwd_flags got=%b/%b exp=1/0", bus.empty_o, bus.full_o);
      end
`ifdef UART_TXQ_OVF_CNT_EN
      checks++; if (bus.ovf_cnt_o !== 8'h00) begin failures++; $display("FAIL rwd_ovf got=%0h exp=00", bus.ovf_cnt_o); end
      ovf_mdl = 0;
`endif
      frames.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      p0 = pulse_cnt;
      cyc = 0;
      while (busy_model === 1'b1 && cyc < 600) begin @(negedge clk); cyc++; end
      checks++; if (cyc >= 600) begin failures++; $display("FAIL rwd_frame_timeout got=%0d exp<600", cyc); end
      repeat (20) @(negedge clk);
      checks++; if (pulse_cnt != p0) begin failures++; $display("FAIL rwd_no_irq got=%0d exp=0", pulse_cnt - p0); end
      checks++; if (bus.level_o !== LW'(0) || bus.empty_o !== 1'b1) begin
         failures++; $display("FAIL rwd_still_empty got=%0d exp=0", bus.level_o);
      end
      hold_len = 30;
      bus.push_i = 1'b1; bus.push_data_i = 8'h77;
      @(negedge clk);
      bus.push_i = 1'b0;
      wait_drain(1, 300);
      checks++; if (frames.size() != 1 || frames[0] !== 8'h77) begin
         failures++; $display("FAIL rwd_new_push got=%0d frames exp=1 of 77", frames.size());
      end
   endtask

   initial begin
      bus.push_i = 1'b0;
      bus.push_data_i = 8'h00;
      busy_manual = 1'b0;
      busy_model = 1'b0;
      model_en = 1'b0;
      #1;
      test_reset();
      test_single();
      test_retry();
      test_abc();
      test_fill_overflow();
      test_random();
      test_reset_wait_done();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-002 SHALL have parameter RETRY_WAIT, default 8, meaning cycles to wait for tx_busy_i after a tx_irq_o pulse.
REQ-003 clk_i  input  1  single system clock, all logic on posedge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 push_i  input  1  write strobe, one byte per high cycle.
REQ-006 push_data_i  input  8  byte to enqueue.
REQ-007 full_o  output  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 empty_o  output  1  FIFO holds 0 bytes.
REQ-009 level_o  output  DEPTH_LOG2+1  current byte count.
REQ-010 tx_irq_o  output  1  1-clk send request to the UART transmitter.
REQ-011 tx_data_o  output  8  byte offered to the UART transmitter.
REQ-012 tx_busy_i  input  1  UART transmitter busy; 1 means a frame is in progress.

Function
REQ-013 Push with full_o=0 SHALL write push_data_i at the write pointer; level_o SHALL rise next cycle.
REQ-014 Push with full_o=1 SHALL be dropped, even if a pop occurs in the same cycle; FIFO contents unchanged.
REQ-015 Push and pop in the same cycle with full_o=0 SHALL leave level_o unchanged; pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE with empty_o=0 and tx_busy_i=0: pop head into tx_data_o and go to ISSUE next cycle; otherwise stay.
REQ-018 ISSUE: tx_irq_o=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: tx_busy_i=1 goes to WAIT_DONE; after RETRY_WAIT cycles without busy, return to ISSUE with the same byte and no new pop.
REQ-020 WAIT_DONE: tx_busy_i=0 goes to IDLE.
REQ-021 tx_data_o SHALL stay constant from the ISSUE cycle until return to IDLE, because the transmitter samples data up to 2 cycles after tx_irq_o.
REQ-022 tx_irq_o SHALL be low for at least 3 cycles between pulses, so that the transmitter's edge detector sees every request.
REQ-023 Back-to-back pops are not allowed; minimum interval is one full UART frame.

Reset
REQ-024 On rst_i=1, outputs SHALL go immediately to: tx_irq_o=0, tx_data_o=8'h00, level_o=0, empty_o=1, full_o=0; FSM to IDLE; pointers to 0.
REQ-025 Reset during WAIT_DONE SHALL discard the in-flight byte and all queued bytes; the frame already on the line completes in the transmitter.

Configuration
REQ-026 With macro UART_TXQ_OVF_CNT_EN defined, SHALL add output ovf_cnt_o[7:0], incremented once per dropped push and saturating at 8'hFF, reset to 0.
REQ-027 Without UART_TXQ_OVF_CNT_EN, ovf_cnt_o and its counter SHALL be absent; all other behaviour identical.

Structure
REQ-028 FSM state encoding and the default depth/retry constants SHALL live in shared package uart_pkg.
REQ-029 Storage and pointers SHALL be in sub-module uart_sync_fifo (parameterised width/depth, with full/empty/level); uart_tx_queue contains the FSM and the ovf counter.

Verification
REQ-030 Reset, then push 8'h41 with tx_busy_i idle -> tx_irq_o one-cycle pulse 2 cycles after the push, tx_data_o=8'h41, level_o back to 0.
REQ-031 Push 16 bytes 8'h00..8'h0F while tx_busy_i is held 1 -> full_o=1, level_o=16; a 17th push is dropped (ovf_cnt_o=1 if enabled).
REQ-032 Model busy: rise 3 cycles after irq, hold 434 cycles; push "ABC" -> three pulses in order 41,42,43, each only after busy falls; tx_data_o stable during each busy window.
REQ-033 Hold tx_busy_i=0 after a pulse -> tx_irq_o re-pulses after 8 cycles with the same byte, and level_o does not change.
REQ-034 Assert rst_i in WAIT_DONE with 5 bytes queued -> outputs reach reset values asynchronously; no tx_irq_o after release until a new push.
REQ-035 Push while full, 300 times, with the macro defined -> ovf_cnt_o=8'hFF, no wrap.
